// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU codes, RV32 opcode/funct constants, FSM state encoding and the instruction decoder
package alu_issue_pkg;
  localparam logic [6:0] ALU_ADD = 7'd0, ALU_MUL = 7'd2, ALU_LW = 7'd3, ALU_ADDI = 7'd4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ADD = 7'b0000000, F7_MUL = 7'b0000001;
  localparam logic [2:0] F3_ADD = 3'b000, F3_LW = 3'b010;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;
  typedef struct packed {
    logic       legal;
    logic       rtype;
    logic [6:0] code;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.rtype = w[6:0] == OP_R && w[14:12] == F3_ADD && (w[31:25] == F7_ADD || w[31:25] == F7_MUL);
    d.legal = d.rtype || (w[6:0] == OP_LOAD && w[14:12] == F3_LW) || (w[6:0] == OP_IMM && w[14:12] == F3_ADD);
    d.code = d.rtype ? (w[31:25] == F7_MUL ? ALU_MUL : ALU_ADD) : w[6:0] == OP_LOAD ? ALU_LW : ALU_ADDI;
    return d;
  endfunction
endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: 32x32 register file (clk/rst, one sync write port we/waddr/wdata, comb reads ra1/ra2/dbg_addr), x0 hardwired to 0
module alu_issue_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] dbg_data
);
  logic [31:0] regs [32];
  always_ff @(posedge clk) begin
    if (rst) regs <= '{default: '0};
    else if (we && waddr != 5'd0) regs[waddr] <= wdata;
  end
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
  assign dbg_data = dbg_addr == 5'd0 ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: 3-cycle issue FSM; instr_valid/instr/instr_ready in, opcode/datain/datain2 to ALU, alu_out back, wb/mem_addr/illegal pulses, dbg read
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [6:0]  opcode,
  output logic [31:0] datain,
  output logic [31:0] datain2,
  input  logic [31:0] alu_out,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_addr_valid,
  output logic [31:0] mem_addr,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  state_t state, state_nx;
  dec_t dec;
  logic [4:0] rd;
  logic [31:0] rs1_val, rs2_val;
  logic accept, we;
  assign dec = decode(instr);
  assign instr_ready = state == S_IDLE;
  assign accept = instr_ready && instr_valid;
  assign we = state == S_WB && opcode != ALU_LW;
  alu_issue_regfile u_rf (
    .clk(clk), .rst(rst), .we(we), .waddr(rd), .wdata(alu_out),
    .ra1(instr[19:15]), .ra2(instr[24:20]), .dbg_addr(dbg_addr),
    .rd1(rs1_val), .rd2(rs2_val), .dbg_data(dbg_data)
  );
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state == S_IDLE ? (accept && dec.legal ? S_EXEC : S_IDLE) : state == S_EXEC ? S_WB : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode <= '0;
      datain <= '0;
      datain2 <= '0;
      rd <= '0;
      illegal <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      mem_addr_valid <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (accept && dec.legal) begin
        opcode <= dec.code;
        datain <= rs1_val;
        datain2 <= dec.rtype ? rs2_val : {{20{instr[31]}}, instr[31:20]};
        rd <= instr[11:7];
      end
      illegal <= accept && !dec.legal;
      wb_valid <= we;
      wb_rd <= rd;
      wb_data <= alu_out;
      mem_addr_valid <= state == S_WB && opcode == ALU_LW;
      mem_addr <= alu_out;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench with an architectural model and a per-cycle compare process
module tb_alu_issue;
  logic clk = 0, rst = 1, instr_valid = 0, instr_ready;
  logic [31:0] instr = 0, datain, datain2, alu_out = 0, wb_data, mem_addr, dbg_data;
  logic [6:0] opcode;
  logic wb_valid, mem_addr_valid, illegal;
  logic [4:0] wb_rd, dbg_addr = 0;
  int cyc = 0, vecs = 0, errs = 0;
  bit armed = 0;
  logic [31:0] mregs [32];
  logic [4:0] exp_rd [int];
  logic [31:0] exp_wd [int];
  logic [31:0] exp_ma [int];
  bit exp_ill [int];
  bit busy [int];
  logic [6:0] e_op = 0;
  logic [31:0] e_a = 0, e_b = 0, last_ma = 0;
  logic [4:0] seen_rd [$];
  localparam logic [31:0] JUNK = 32'h06300493;
  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .opcode(opcode), .datain(datain), .datain2(datain2), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_addr_valid(mem_addr_valid), .mem_addr(mem_addr), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) alu_out <= opcode == 7'd2 ? datain * datain2 : datain + datain2;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask
  always @(negedge clk) begin
    int n;
    if (armed) begin
      n = cyc;
      chk("instr_ready", 32'(instr_ready), 32'(busy.exists(n) == 0));
      chk("wb_valid", 32'(wb_valid), 32'(exp_rd.exists(n) != 0));
      if (exp_rd.exists(n)) begin
        chk("wb_rd", 32'(wb_rd), 32'(exp_rd[n]));
        chk("wb_data", wb_data, exp_wd[n]);
        if (exp_rd[n] != 5'd0) mregs[exp_rd[n]] = exp_wd[n];
      end
      if (wb_valid) seen_rd.push_back(wb_rd);
      chk("mem_addr_valid", 32'(mem_addr_valid), 32'(exp_ma.exists(n) != 0));
      if (exp_ma.exists(n)) chk("mem_addr", mem_addr, exp_ma[n]);
      if (mem_addr_valid) last_ma = mem_addr;
      chk("illegal", 32'(illegal), 32'(exp_ill.exists(n) != 0));
      chk("opcode", 32'(opcode), 32'(e_op));
      chk("datain", datain, e_a);
      chk("datain2", datain2, e_b);
      chk("dbg_data", dbg_data, dbg_addr == 5'd0 ? 32'd0 : mregs[dbg_addr]);
    end
  end
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] rop(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  task automatic issue(input logic [31:0] w, input bit full = 1);
    logic [31:0] a, b, res;
    logic [6:0] code;
    int k;
    bit ok;
    instr = w;
    instr_valid = 1;
    @(posedge clk);
    #1 k = cyc;
    a = mregs[w[19:15]];
    b = 0;
    res = 0;
    code = 0;
    ok = 1;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) begin
      code = 7'd0; b = mregs[w[24:20]]; res = a + b;
    end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h01) begin
      code = 7'd2; b = mregs[w[24:20]]; res = a * b;
    end else if (w[6:0] == 7'h03 && w[14:12] == 3'd2) begin
      code = 7'd3; b = {{20{w[31]}}, w[31:20]}; res = a + b;
    end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      code = 7'd4; b = {{20{w[31]}}, w[31:20]}; res = a + b;
    end else ok = 0;
    if (!ok) begin
      exp_ill[k] = 1;
      @(negedge clk);
      return;
    end
    e_op = code; e_a = a; e_b = b;
    busy[k] = 1;
    busy[k + 1] = 1;
    if (code == 7'd3) exp_ma[k + 2] = res;
    else begin
      exp_rd[k + 2] = w[11:7];
      exp_wd[k + 2] = res;
    end
    instr = JUNK;
    if (full) repeat (3) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    instr_valid = 0;
    @(posedge clk);
    #1;
    exp_rd.delete(); exp_wd.delete(); exp_ma.delete(); exp_ill.delete(); busy.delete();
    foreach (mregs[i]) mregs[i] = 0;
    e_op = 0; e_a = 0; e_b = 0;
    armed = 1;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic idle(input int n);
    instr_valid = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic check_reg(input logic [4:0] a, input logic [31:0] lit);
    @(negedge clk);
    #1 dbg_addr = a;
    #1 chk($sformatf("x%0d", a), dbg_data, lit);
  endtask
  initial begin
    do_reset();
    check_reg(5'd1, 32'd0);
    issue(addi(5'd1, 5'd0, 12'd5));
    issue(addi(5'd2, 5'd0, 12'd7));
    issue(rop(7'h00, 5'd3, 5'd1, 5'd2));
    idle(2);
    check_reg(5'd3, 32'd12);
    chk("wb_count", 32'(seen_rd.size()), 32'd3);
    chk("wb_order0", 32'(seen_rd[0]), 32'd1);
    chk("wb_order1", 32'(seen_rd[1]), 32'd2);
    chk("wb_order2", 32'(seen_rd[2]), 32'd3);
    issue(addi(5'd1, 5'd0, 12'hFFF));
    issue(addi(5'd4, 5'd1, 12'd1));
    issue(addi(5'd5, 5'd0, 12'hFFF));
    idle(2);
    check_reg(5'd1, 32'hFFFFFFFF);
    check_reg(5'd4, 32'd0);
    check_reg(5'd5, 32'hFFFFFFFF);
    issue(addi(5'd1, 5'd0, 12'h100));
    issue(rop(7'h01, 5'd1, 5'd1, 5'd1));
    issue(rop(7'h00, 5'd2, 5'd1, 5'd0));
    issue(rop(7'h01, 5'd6, 5'd1, 5'd2));
    idle(2);
    check_reg(5'd1, 32'h10000);
    check_reg(5'd6, 32'd0);
    issue(addi(5'd2, 5'd0, 12'd3));
    issue(addi(5'd1, 5'd0, 12'd5));
    issue(rop(7'h01, 5'd6, 5'd1, 5'd2));
    idle(2);
    check_reg(5'd6, 32'd15);
    issue(addi(5'd1, 5'd0, 12'h100));
    issue(lw(5'd7, 5'd1, 12'hFFC));
    idle(2);
    check_reg(5'd7, 32'd0);
    chk("lw_addr", last_ma, 32'hFC);
    issue(rop(7'h00, 5'd0, 5'd1, 5'd1));
    issue(32'hFFFFFFFF);
    issue(rop(7'h20, 5'd8, 5'd1, 5'd1));
    issue({12'd1, 5'd1, 3'b001, 5'd8, 7'h13});
    issue({12'd1, 5'd1, 3'b000, 5'd8, 7'h03});
    idle(2);
    check_reg(5'd0, 32'd0);
    check_reg(5'd1, 32'h100);
    check_reg(5'd8, 32'd0);
    issue(addi(5'd8, 5'd0, 12'd1), 0);
    do_reset();
    idle(3);
    for (int i = 0; i < 32; i++) check_reg(5'(i), 32'd0);
    issue(addi(5'd10, 5'd0, 12'd3), 0);
    @(negedge clk);
    do_reset();
    idle(3);
    check_reg(5'd10, 32'd0);
    issue(addi(5'd9, 5'd0, 12'd2));
    idle(2);
    check_reg(5'd9, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
- Parameters: none; datapath width fixed at 32 bits, 32 architectural registers.
- REQ-001: clk  input  1  single clock; all state updates on posedge clk.
- REQ-002: rst  input  1  reset, synchronous, active-high.
- REQ-003: instr_valid  input  1  upstream presents an instruction word.
- REQ-004: instr  input  32  RV32 instruction word.
- REQ-005: instr_ready  output  1  block accepts instr this cycle.
- REQ-006: opcode  output  7  registered ALU operation code.
- REQ-007: datain  output  32  registered ALU operand A (rs1 value).
- REQ-008: datain2  output  32  registered ALU operand B (rs2 value or immediate).
- REQ-009: alu_out  input  32  registered ALU result, valid one cycle after operands are sampled.
- REQ-010: wb_valid / wb_rd / wb_data  output  1/5/32  pulse marking a register-file write.
- REQ-011: mem_addr_valid / mem_addr  output  1/32  pulse carrying an LW effective address.
- REQ-012: illegal  output  1  pulse on an accepted undecodable instruction.
- REQ-013: dbg_addr  input  5 / dbg_data  output  32  combinational register-file read for test.

Function
- REQ-014: Decode table (ALU code): R-type 0110011 f3=000 f7=0000000 ADD -> 0; f7=0000001 MUL -> 2; 0000011 f3=010 LW -> 3; 0010011 f3=000 ADDI -> 4; anything else illegal.
- REQ-015: Operand B SHALL be rs2 for R-type, sign-extended instr[31:20] for LW/ADDI.
- REQ-016: FSM states IDLE, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
- REQ-017: IDLE & instr_valid & legal at edge E0 -> opcode/datain/datain2 registered, rd latched, state EXEC.
- REQ-018: EXEC -> WB at E1 (ALU samples operands at E1); operands held stable EXEC through WB.
- REQ-019: WB -> IDLE at E2; at E2 ADD/MUL/ADDI write alu_out to rd, with wb_valid=1, wb_rd, wb_data asserted for the cycle following E2.
- REQ-020: LW in WB SHALL NOT write the register file; mem_addr_valid=1 and mem_addr=alu_out for the cycle following E2.
- REQ-021: Writes to x0 SHALL be suppressed (wb_valid still pulses, wb_rd=0); x0 SHALL always read 0.
- REQ-022: Illegal instruction in IDLE -> accepted, illegal=1 next cycle, no operand update, stays IDLE.
- REQ-023: Throughput one instruction per 3 cycles; next accept no earlier than E3.
- REQ-024: Register reads SHALL occur at accept, so a dependent instruction accepted at E3 sees the E2 write.
- REQ-025: MUL result SHALL be the low 32 bits; all additions wrap modulo 2^32.
- REQ-026: instr is ignored outside IDLE; no buffering.

Reset
- REQ-027: rst high at an edge -> state IDLE, opcode=0, datain=0, datain2=0, all pulses 0, all 32 registers 0.
- REQ-028: rst during EXEC/WB SHALL abandon the in-flight instruction with no writeback and no mem_addr_valid.
- REQ-029: instr_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
- REQ-030: Shared package holds the ALU code constants (ADD=0, MUL=2, LW=3, ADDI=4), RV opcode/funct constants, and the FSM state encoding.
- REQ-031: One sub-module, alu_issue_regfile (32x32, one sync write port, two combinational read ports plus debug port).

Verification
- REQ-032: ADDI x1,x0,5 then ADDI x2,x0,7 then ADD x3,x1,x2 -> dbg x3=12; wb_rd 1,2,3 in order.
- REQ-033: x1=0xFFFFFFFF, ADDI x4,x1,1 -> x4=0 (wrap); ADDI x5,x0,-1 -> x5=0xFFFFFFFF.
- REQ-034: x1=0x10000, x2=0x10000, MUL x6,x1,x2 -> x6=0; x2=3, MUL with x1=5 -> 15.
- REQ-035: x1=0x100, LW x7,-4(x1) -> mem_addr=0xFC pulse, x7 unchanged, no register write.
- REQ-036: ADD x0,x1,x1 -> x0 reads 0; instr 0xFFFFFFFF -> illegal pulse, registers unchanged.
- REQ-037: rst asserted in EXEC -> no wb_valid, all registers 0, instr_ready=1 next cycle.
